memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 135 +++++++++++++
 tb/tb_memory_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// memory_stage : pipeline MEM stage with request/ready data bus, stall and timeout
// Revision     : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int BASE_ADDR = 1024,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writebackEnabledIn,
    input  logic        memoryReadEnabledIn,
    input  logic        memoryWriteEnabledIn,
    input  logic [31:0] aluResultIn,
    input  logic [31:0] valRmIn,
    input  logic [3:0]  destinationIn,
    output logic        writebackEnabled,
    output logic        memoryReadEnabled,
    output logic [31:0] aluResult,
    output logic [3:0]  destination,
    output logic [31:0] memoryResult,
    output logic        freeze,
    output logic        busError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic        memReady,
    input  logic [31:0] memRdata
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [31:0]      BASE_VEC    = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]       mem_result_q, mem_result_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              bus_error_q, bus_error_d;
    logic              w_access;
    logic [31:0]       w_offset;

    assign w_access = memoryReadEnabledIn | memoryWriteEnabledIn;
    assign w_offset = aluResultIn - BASE_VEC;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_result_d = mem_result_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        bus_error_d  = bus_error_q;
        case (state_q)
            IDLE: begin
                if (w_access) begin
                    state_d     = REQ;
                    mem_addr_d  = {w_offset[31:2], 2'b00};
                    mem_wdata_d = valRmIn;
                    // A simultaneous read+write request is treated as a pure store
                    mem_we_d    = memoryWriteEnabledIn;
                end
            end
            REQ: begin
                if (memReady) begin
                    state_d = DONE;
                    if (!mem_we_q) begin
                        mem_result_d = memRdata;
                    end
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d     = DONE;
                    bus_error_d = 1'b1;
                    if (!mem_we_q) begin
                        mem_result_d = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            mem_result_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_result_q <= mem_result_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Stall decoded from state so an async reset releases the bus immediately
    assign freeze            = ((state_q == IDLE) && w_access) || (state_q == REQ);
    assign memReq            = (state_q == REQ);
    assign memWe             = mem_we_q;
    assign memAddr           = mem_addr_q;
    assign memWdata          = mem_wdata_q;
    assign memoryResult      = mem_result_q;
    assign busError          = bus_error_q;
    assign writebackEnabled  = writebackEnabledIn;
    assign memoryReadEnabled = memoryReadEnabledIn;
    assign aluResult         = aluResultIn;
    assign destination       = destinationIn;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// tb_memory_stage : directed, self-checking bench for memory_stage
// Revision        : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    localparam int BASE_ADDR = 1024;
    localparam int TIMEOUT   = 15;

    logic        clk;
    logic        rst_n;
    logic        writebackEnabledIn, memoryReadEnabledIn, memoryWriteEnabledIn;
    logic [31:0] aluResultIn, valRmIn;
    logic [3:0]  destinationIn;
    logic        writebackEnabled, memoryReadEnabled;
    logic [31:0] aluResult;
    logic [3:0]  destination;
    logic [31:0] memoryResult;
    logic        freeze, busError, memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic        memReady;
    logic [31:0] memRdata;

    memory_stage #(.BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT)) dut (
        .clk                 (clk),
        .rst                 (rst_n),
        .writebackEnabledIn  (writebackEnabledIn),
        .memoryReadEnabledIn (memoryReadEnabledIn),
        .memoryWriteEnabledIn(memoryWriteEnabledIn),
        .aluResultIn         (aluResultIn),
        .valRmIn             (valRmIn),
        .destinationIn       (destinationIn),
        .writebackEnabled    (writebackEnabled),
        .memoryReadEnabled   (memoryReadEnabled),
        .aluResult           (aluResult),
        .destination         (destination),
        .memoryResult        (memoryResult),
        .freeze              (freeze),
        .busError            (busError),
        .memReq              (memReq),
        .memWe               (memWe),
        .memAddr             (memAddr),
        .memWdata            (memWdata),
        .memReady            (memReady),
        .memRdata            (memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level expectations, written by the stimulus process
    logic        exp_on, exp_freeze, exp_req, exp_bus, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [31:0] mdl_result;
    logic        mdl_buserr;
    int          freeze_run  = 0;
    int          last_run    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (freeze) freeze_run++;
            else if (freeze_run > 0) begin
                last_run   = freeze_run;
                freeze_run = 0;
            end
        end
        if (exp_on && rst_n) begin
            chk("freeze", 32'(freeze), 32'(exp_freeze));
            chk("memReq", 32'(memReq), 32'(exp_req));
            chk("busError", 32'(busError), 32'(mdl_buserr));
            chk("memoryResult", memoryResult, mdl_result);
            chk("aluResult", aluResult, aluResultIn);
            chk("destination", 32'(destination), 32'(destinationIn));
            chk("wbCopy", 32'(writebackEnabled), 32'(writebackEnabledIn));
            chk("rdCopy", 32'(memoryReadEnabled), 32'(memoryReadEnabledIn));
            if (exp_bus) begin
                chk("memAddr", memAddr, exp_addr);
                chk("memWdata", memWdata, exp_wdata);
                chk("memWe", 32'(memWe), 32'(exp_we));
            end
        end
    end

    // One complete access; ready_at = REQ cycle carrying memReady, 0 = never
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] alu,
                             input logic [31:0] wd, input int ready_at,
                             input logic [31:0] rdata);
        @(posedge clk); #1;
        memoryReadEnabledIn  = rd;
        memoryWriteEnabledIn = wr;
        aluResultIn          = alu;
        valRmIn              = wd;
        memReady             = 1'b0;
        exp_freeze = 1'b1; exp_req = 1'b0; exp_bus = 1'b0;
        exp_addr   = (alu - 32'(BASE_ADDR)) & 32'hFFFF_FFFC;
        exp_wdata  = wd;
        exp_we     = wr;
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(posedge clk); #1;
            exp_freeze = 1'b1; exp_req = 1'b1; exp_bus = 1'b1;
            memReady   = (k == ready_at);
            memRdata   = (k == ready_at) ? rdata : 32'hDEAD_BEEF;
            if (k == ready_at) break;
        end
        @(posedge clk); #1;
        memReady = 1'b0;
        if (!wr) mdl_result = (ready_at > 0) ? rdata : 32'h0;
        if (ready_at == 0) mdl_buserr = 1'b1;
        exp_freeze = 1'b0; exp_req = 1'b0;
        // access is still requested in DONE; next cycle must be a plain IDLE
        @(posedge clk); #1;
        memoryReadEnabledIn  = 1'b0;
        memoryWriteEnabledIn = 1'b0;
        exp_bus = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        writebackEnabledIn = 1'b0; memoryReadEnabledIn = 1'b0; memoryWriteEnabledIn = 1'b0;
        aluResultIn = '0; valRmIn = '0; destinationIn = '0;
        memReady = 1'b0; memRdata = '0;
        exp_on = 1'b0; exp_freeze = 1'b0; exp_req = 1'b0; exp_bus = 1'b0; exp_we = 1'b0;
        exp_addr = '0; exp_wdata = '0;
        mdl_result = '0; mdl_buserr = 1'b0;

        #12;
        chk("rst_memReq", 32'(memReq), 32'h0);
        chk("rst_busError", 32'(busError), 32'h0);
        chk("rst_memoryResult", memoryResult, 32'h0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_memWdata", memWdata, 32'h0);
        chk("rst_memWe", 32'(memWe), 32'h0);
        chk("rst_freeze", 32'(freeze), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 exp_on = 1'b1;

        // Non-memory instruction passes straight through
        writebackEnabledIn = 1'b1; aluResultIn = 32'h55; destinationIn = 4'd3;
        repeat (4) @(posedge clk);
        #1;
        chk("pass_aluResult", aluResult, 32'h55);
        chk("pass_destination", 32'(destination), 32'd3);
        chk("pass_freeze", 32'(freeze), 32'h0);

        // Store, ready in 3rd REQ cycle
        do_access(1'b0, 1'b1, 32'd1028, 32'hCAFE_F00D, 3, 32'h0);
        chk("store_addr", memAddr, 32'h0000_0004);
        chk("store_wdata", memWdata, 32'hCAFE_F00D);
        chk("store_we", 32'(memWe), 32'h1);
        chk("store_freeze_len", 32'(last_run), 32'd4);

        // Load, ready in 1st REQ cycle
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, 1, 32'h1234_5678);
        chk("load_result", memoryResult, 32'h1234_5678);
        chk("load_addr", memAddr, 32'h0000_0008);
        chk("load_freeze_len", 32'(last_run), 32'd2);

        // Read+write together: store only, load data untouched
        do_access(1'b1, 1'b1, 32'd1100, 32'h0000_1111, 2, 32'h9999_9999);
        chk("both_result", memoryResult, 32'h1234_5678);
        chk("both_we", 32'(memWe), 32'h1);

        // Address below base wraps
        do_access(1'b1, 1'b0, 32'd1000, 32'h0, 2, 32'h0BAD_F00D);
        chk("under_addr", memAddr, 32'hFFFF_FFE8);
        chk("under_freeze_len", 32'(last_run), 32'd3);

        // Load timeout
        do_access(1'b1, 1'b0, 32'd1036, 32'h0, 0, 32'h0);
        chk("to_busError", 32'(busError), 32'h1);
        chk("to_result", memoryResult, 32'h0);
        chk("to_freeze_len", 32'(last_run), 32'(TIMEOUT + 2));

        // Reset pulse in the middle of a request
        @(posedge clk); #1;
        exp_on = 1'b0;
        memoryReadEnabledIn = 1'b1; aluResultIn = 32'd1040;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_memReq", 32'(memReq), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_memReq", 32'(memReq), 32'h0);
        chk("midrst_busError", 32'(busError), 32'h0);
        chk("midrst_result", memoryResult, 32'h0);
        chk("midrst_freeze", 32'(freeze), 32'h1);
        mdl_buserr = 1'b0; mdl_result = 32'h0;
        memoryReadEnabledIn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        freeze_run = 0;
        #1;
        exp_on = 1'b1; exp_freeze = 1'b0; exp_req = 1'b0; exp_bus = 1'b0;
        do_access(1'b1, 1'b0, 32'd1044, 32'h0, 2, 32'hA5A5_0001);
        chk("post_rst_result", memoryResult, 32'hA5A5_0001);
        chk("post_rst_addr", memAddr, 32'h0000_0014);
        chk("post_rst_freeze_len", 32'(last_run), 32'd3);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
